// File: rtl/sdram_arbit.sv
// SDRAM command arbiter and pin multiplexer.
// Grants refresh > write > read and routes the winner onto the pins.
module sdram_arbit #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              aref_end,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DQ_W-1:0]   wr_data,
  input  logic              wr_sdram_en,
  input  logic              wr_end,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_end,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DQ_W-1:0]   sdram_dq_out,
  output logic              sdram_dq_oe
);

  localparam logic [3:0] NOP = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    ARBIT,
    AREF,
    WRITE,
    READ
  } state_t;

  state_t state;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      sdram_cke <= 1'b0;
    end else begin
      sdram_cke <= 1'b1;
      case (state)
        IDLE:
          if (init_end) state <= ARBIT;
        ARBIT:
          if (aref_req)    state <= AREF;
          else if (wr_req) state <= WRITE;
          else if (rd_req) state <= READ;
        AREF:
          if (aref_end) state <= ARBIT;
        WRITE:
          if (wr_end) state <= ARBIT;
        READ:
          if (rd_end) state <= ARBIT;
        default:
          state <= IDLE;
      endcase
    end
  end

  assign aref_en = (state == AREF);
  assign wr_en   = (state == WRITE);
  assign rd_en   = (state == READ);

  logic [3:0] cmd;

  always_comb begin
    cmd        = NOP;
    sdram_ba   = '1;
    sdram_addr = '1;
    case (state)
      IDLE: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      AREF: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        cmd        = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: begin
        cmd        = NOP;
        sdram_ba   = '1;
        sdram_addr = '1;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

  // DQ is only driven while the write module owns the bus
  assign sdram_dq_oe  = wr_en & wr_sdram_en;
  assign sdram_dq_out = sdram_dq_oe ? wr_data : '0;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit.
// Expected pin vectors are queued per step and popped after each edge.
module tb_sdram_arbit;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [12:0] init_addr;
  logic        init_end;
  logic        aref_req, aref_end, aref_en;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_ba;
  logic [12:0] aref_addr;
  logic        wr_req, wr_end, wr_en, wr_sdram_en;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_req, rd_end, rd_en;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [12:0] rd_addr;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n;
  logic        sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;

  always #5 sys_clk = ~sys_clk;

  sdram_arbit #(
    .ADDR_W(13),
    .BA_W  (2),
    .DQ_W  (16)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .init_cmd    (init_cmd),
    .init_ba     (init_ba),
    .init_addr   (init_addr),
    .init_end    (init_end),
    .aref_req    (aref_req),
    .aref_cmd    (aref_cmd),
    .aref_ba     (aref_ba),
    .aref_addr   (aref_addr),
    .aref_end    (aref_end),
    .aref_en     (aref_en),
    .wr_req      (wr_req),
    .wr_cmd      (wr_cmd),
    .wr_ba       (wr_ba),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_sdram_en (wr_sdram_en),
    .wr_end      (wr_end),
    .wr_en       (wr_en),
    .rd_req      (rd_req),
    .rd_cmd      (rd_cmd),
    .rd_ba       (rd_ba),
    .rd_addr     (rd_addr),
    .rd_end      (rd_end),
    .rd_en       (rd_en),
    .sdram_cke   (sdram_cke),
    .sdram_cs_n  (sdram_cs_n),
    .sdram_ras_n (sdram_ras_n),
    .sdram_cas_n (sdram_cas_n),
    .sdram_we_n  (sdram_we_n),
    .sdram_ba    (sdram_ba),
    .sdram_addr  (sdram_addr),
    .sdram_dq_out(sdram_dq_out),
    .sdram_dq_oe (sdram_dq_oe)
  );

  typedef struct {
    string       tag;
    logic [39:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {cke, aref_en, wr_en, rd_en, cmd, ba, addr, oe, dq}
  function automatic logic [39:0] mk(
    input logic        cke,
    input logic [2:0]  g,
    input logic [3:0]  cmd,
    input logic [1:0]  ba,
    input logic [12:0] addr,
    input logic        oe,
    input logic [15:0] dq
  );
    return {cke, g, cmd, ba, addr, oe, dq};
  endfunction

  localparam logic [3:0]  IC = 4'b0010;
  localparam logic [1:0]  IB = 2'b01;
  localparam logic [12:0] IA = 13'h0400;
  localparam logic [3:0]  AC = 4'b0001;
  localparam logic [1:0]  AB = 2'b00;
  localparam logic [12:0] AA = 13'h0000;
  localparam logic [3:0]  WC = 4'b0100;
  localparam logic [1:0]  WB = 2'b10;
  localparam logic [12:0] WA = 13'h0123;
  localparam logic [3:0]  RC = 4'b0101;
  localparam logic [1:0]  RB = 2'b11;
  localparam logic [12:0] RA = 13'h0456;

  function automatic logic [39:0] e_idle(input logic cke);
    return mk(cke, 3'b000, IC, IB, IA, 1'b0, 16'h0);
  endfunction
  function automatic logic [39:0] e_arb();
    return mk(1'b1, 3'b000, 4'b0111, 2'b11, 13'h1fff, 1'b0, 16'h0);
  endfunction
  function automatic logic [39:0] e_aref();
    return mk(1'b1, 3'b100, AC, AB, AA, 1'b0, 16'h0);
  endfunction
  function automatic logic [39:0] e_wr(input logic oe, input logic [15:0] d);
    return mk(1'b1, 3'b010, WC, WB, WA, oe, d);
  endfunction
  function automatic logic [39:0] e_rd();
    return mk(1'b1, 3'b001, RC, RB, RA, 1'b0, 16'h0);
  endfunction

  task automatic step(input string tag, input logic [39:0] e);
    exp_t x;
    logic [39:0] obs;
    sb.push_back('{tag, e});
    @(posedge sys_clk);
    #1;
    x   = sb.pop_front();
    obs = {sdram_cke, aref_en, wr_en, rd_en,
           sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
           sdram_ba, sdram_addr, sdram_dq_oe, sdram_dq_out};
    n_cmp++;
    assert (obs === x.v) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.v);
    end
  endtask

  initial begin
    sys_rst     = 1'b1;
    init_cmd    = IC;
    init_ba     = IB;
    init_addr   = IA;
    init_end    = 1'b0;
    aref_req    = 1'b0;
    aref_cmd    = AC;
    aref_ba     = AB;
    aref_addr   = AA;
    aref_end    = 1'b0;
    wr_req      = 1'b0;
    wr_cmd      = WC;
    wr_ba       = WB;
    wr_addr     = WA;
    wr_data     = 16'h0;
    wr_sdram_en = 1'b0;
    wr_end      = 1'b0;
    rd_req      = 1'b0;
    rd_cmd      = RC;
    rd_ba       = RB;
    rd_addr     = RA;
    rd_end      = 1'b0;

    for (int i = 0; i < 3; i++) step("reset", e_idle(1'b0));
    sys_rst = 1'b0;
    for (int i = 0; i < 10; i++) step("init", e_idle(1'b1));
    init_end = 1'b1;
    step("to_arbit", e_arb());
    step("arbit_hold", e_arb());

    aref_req = 1'b1;
    wr_req   = 1'b1;
    rd_req   = 1'b1;
    step("prio_aref", e_aref());
    aref_req = 1'b0;
    step("aref_hold", e_aref());
    aref_end = 1'b1;
    step("aref_done", e_arb());
    aref_end = 1'b0;
    step("prio_wr", e_wr(1'b0, 16'h0));

    wr_sdram_en = 1'b1;
    wr_data     = 16'hA5C3;
    aref_req    = 1'b1;
    step("wr_dq", e_wr(1'b1, 16'hA5C3));
    wr_sdram_en = 1'b0;
    step("wr_dq_off", e_wr(1'b0, 16'h0));
    wr_req = 1'b0;
    wr_end = 1'b1;
    step("wr_done", e_arb());
    wr_end = 1'b0;
    step("aref_after_wr", e_aref());

    aref_req = 1'b0;
    rd_end   = 1'b1;
    step("stray_rd_end", e_aref());
    rd_end   = 1'b0;
    aref_end = 1'b1;
    step("aref_done2", e_arb());
    aref_end    = 1'b0;
    wr_sdram_en = 1'b1;
    step("prio_rd", e_rd());
    step("rd_no_oe", e_rd());

    sys_rst = 1'b1;
    step("midop_reset", e_idle(1'b0));
    sys_rst     = 1'b0;
    rd_req      = 1'b0;
    wr_sdram_en = 1'b0;
    step("reinit_arbit", e_arb());
    wr_end = 1'b1;
    step("stray_wr_end", e_arb());
    wr_end = 1'b0;
    rd_req = 1'b1;
    step("rd_again", e_rd());
    rd_req = 1'b0;
    rd_end = 1'b1;
    step("rd_done", e_arb());
    rd_end = 1'b0;
    step("arbit_idle", e_arb());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
